// File: rtl/jk_cmd_seq.sv
// rtl/jk_cmd_seq.sv - FIFO-buffered command sequencer driving a JK flip-flop stage
// Optional JK_SEQ_PRED_EN adds q/q_pred/mismatch flip-flop prediction.
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int RPT_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_jk,
   input  logic [RPT_W-1:0]        cmd_rpt,
   input  logic                    enable,
`ifdef JK_SEQ_PRED_EN
   input  logic                    q,
   output logic                    q_pred,
   output logic                    mismatch,
`endif
   output logic [1:0]              jk,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   logic [RPT_W+1:0]  mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [RPT_W+1:0]  head;
   logic [1:0]        head_jk;
   logic [RPT_W-1:0]  head_rpt;
   logic              push, pop, empty, full;

   state_t            state, state_nx;
   logic [1:0]        code, code_nx, jk_nx;
   logic [RPT_W-1:0]  cnt, cnt_nx;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head      = mem[rd_ptr];
   assign head_jk   = head[RPT_W+1:RPT_W];
   assign head_rpt  = head[RPT_W-1:0];
   assign busy      = (state == ISSUE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_jk, cmd_rpt};
   end

   // Full blocks pushes even when a pop frees a slot in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         code  <= 2'b00;
         cnt   <= '0;
         jk    <= 2'b00;
      end else begin
         state <= state_nx;
         code  <= code_nx;
         cnt   <= cnt_nx;
         jk    <= jk_nx;
      end
   end

   // Each enabled ISSUE edge either spends one more repeat or retires the command;
   // a disabled edge parks jk at hold without touching the count.
   always_comb begin
      state_nx = state;
      code_nx  = code;
      cnt_nx   = cnt;
      jk_nx    = 2'b00;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && enable) begin
               pop      = 1'b1;
               code_nx  = head_jk;
               cnt_nx   = head_rpt;
               jk_nx    = head_jk;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (enable) begin
               if (cnt != '0) begin
                  cnt_nx = cnt - 1'b1;
                  jk_nx  = code;
               end else if (!empty) begin
                  pop     = 1'b1;
                  code_nx = head_jk;
                  cnt_nx  = head_rpt;
                  jk_nx   = head_jk;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef JK_SEQ_PRED_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_pred   <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         case (jk)
            2'b01:   q_pred <= 1'b0;
            2'b10:   q_pred <= 1'b1;
            2'b11:   q_pred <= !q_pred;
            default: ;
         endcase
         if (q != q_pred) mismatch <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb/tb_jk_cmd_seq.sv - directed bench for jk_cmd_seq with a queue-based reference model
module tb_jk_cmd_seq;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_jk;
   logic [3:0] cmd_rpt;
   logic       enable;
   logic [1:0] jk;
   logic       busy;
   logic [2:0] level;
   bit         run_chk = 1'b0;
   int         n_vec = 0;
   int         n_miss = 0;

`ifdef JK_SEQ_PRED_EN
   logic q, q_pred, mismatch;
   logic ff_q;
   logic q_force;
   logic m_qpred = 1'b0;
   logic m_mis   = 1'b0;
   assign q = ff_q ^ q_force;
`endif

   jk_cmd_seq #(.DEPTH(DEPTH), .RPT_W(4)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_jk(cmd_jk), .cmd_rpt(cmd_rpt), .enable(enable),
`ifdef JK_SEQ_PRED_EN
      .q(q), .q_pred(q_pred), .mismatch(mismatch),
`endif
      .jk(jk), .busy(busy), .level(level)
   );

   always #5 clk = ~clk;

   // Reference: a command queue plus "extra active cycles still owed" for the current command.
   typedef struct packed {logic [1:0] c; logic [3:0] r;} cmd_t;
   cmd_t       mq[$];
   cmd_t       m_head;
   bit         m_room;
   bit         m_busy = 1'b0;
   int         m_more = 0;
   logic [1:0] m_code = 2'b00;
   logic [1:0] m_jk   = 2'b00;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_busy = 1'b0;
         m_more = 0;
         m_code = 2'b00;
         m_jk   = 2'b00;
`ifdef JK_SEQ_PRED_EN
         m_qpred = 1'b0;
         m_mis   = 1'b0;
`endif
      end else begin
         m_room = (mq.size() < DEPTH);
`ifdef JK_SEQ_PRED_EN
         if (q != m_qpred) m_mis = 1'b1;
         if (m_jk == 2'b01) m_qpred = 1'b0;
         else if (m_jk == 2'b10) m_qpred = 1'b1;
         else if (m_jk == 2'b11) m_qpred = ~m_qpred;
`endif
         if (!enable) begin
            m_jk = 2'b00;
         end else if (m_busy && m_more > 0) begin
            m_more = m_more - 1;
            m_jk   = m_code;
         end else if (mq.size() > 0) begin
            m_head = mq.pop_front();
            m_code = m_head.c;
            m_more = int'(m_head.r);
            m_jk   = m_head.c;
            m_busy = 1'b1;
         end else begin
            m_jk   = 2'b00;
            m_busy = 1'b0;
         end
         if (cmd_valid && m_room) mq.push_back('{c: cmd_jk, r: cmd_rpt});
      end
   end

`ifdef JK_SEQ_PRED_EN
   always @(posedge clk or posedge reset) begin
      if (reset) ff_q <= 1'b0;
      else if (jk == 2'b01) ff_q <= 1'b0;
      else if (jk == 2'b10) ff_q <= 1'b1;
      else if (jk == 2'b11) ff_q <= ~ff_q;
   end
`endif

   function automatic void chk(input string name, input int act, input int exp);
      n_vec = n_vec + 1;
      if (act != exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (run_chk && !reset) begin
         chk("jk", jk, m_jk);
         chk("busy", busy, m_busy);
         chk("level", level, mq.size());
         chk("cmd_ready", cmd_ready, (mq.size() < DEPTH) ? 1 : 0);
`ifdef JK_SEQ_PRED_EN
         chk("q_pred", q_pred, m_qpred);
         chk("mismatch", mismatch, m_mis);
`endif
      end
   end

   task automatic push_cmd(input logic [1:0] c, input logic [3:0] r);
      bit acc;
      int t;
      acc = 1'b0;
      t = 0;
      cmd_valid = 1'b1;
      cmd_jk = c;
      cmd_rpt = r;
      while (!acc && t < 50) begin
         acc = cmd_ready;
         @(negedge clk);
         t++;
      end
      cmd_valid = 1'b0;
      chk("push_accept", acc, 1);
   endtask

   task automatic run_trace(input string name, input int n, input logic [15:0] exp_bits);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(name, jk, exp_bits[2*(n-1-i) +: 2]);
      end
   endtask

   task automatic wait_idle(input int limit);
      bit done;
      done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         @(negedge clk);
         done = !busy && (level == 3'd0);
      end
      chk("drain", done, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_jk = 2'b00;
      cmd_rpt = 4'd0;
      enable = 1'b0;
`ifdef JK_SEQ_PRED_EN
      q_force = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_jk", jk, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", cmd_ready, 1);
      reset = 1'b0;
      run_chk = 1'b1;

      // single command
      enable = 1'b1;
      @(negedge clk);
      push_cmd(2'b11, 4'd2);
      run_trace("single", 5, 16'(10'b11_11_11_00_00));
      chk("single_busy", busy, 0);

      // back-to-back, preloaded while paused
      enable = 1'b0;
      push_cmd(2'b10, 4'd0);
      push_cmd(2'b01, 4'd1);
      push_cmd(2'b11, 4'd0);
      chk("b2b_level", level, 3);
      enable = 1'b1;
      run_trace("b2b", 5, 16'(10'b10_01_01_11_00));

      // pause inside a command
      push_cmd(2'b11, 4'd3);
      run_trace("pause_a", 2, 16'(4'b11_11));
      enable = 1'b0;
      run_trace("pause_b", 2, 16'(4'b00_00));
      chk("pause_busy", busy, 1);
      enable = 1'b1;
      run_trace("pause_c", 3, 16'(6'b11_11_00));

      // FIFO full, pending offer accepted after one pop
      enable = 1'b0;
      push_cmd(2'b10, 4'd3);
      push_cmd(2'b01, 4'd0);
      push_cmd(2'b11, 4'd1);
      push_cmd(2'b00, 4'd2);
      chk("full_level", level, 4);
      chk("full_ready", cmd_ready, 0);
      cmd_valid = 1'b1;
      cmd_jk = 2'b01;
      cmd_rpt = 4'd0;
      @(negedge clk);
      chk("full_hold_level", level, 4);
      chk("full_hold_ready", cmd_ready, 0);
      enable = 1'b1;
      @(negedge clk);
      chk("full_pop_level", level, 3);
      chk("full_pop_ready", cmd_ready, 1);
      @(negedge clk);
      chk("full_accept_level", level, 4);
      cmd_valid = 1'b0;
      wait_idle(40);
      chk("full_drain_jk", jk, 0);

      // reset in the middle of an issue with 3 entries queued
      enable = 1'b0;
      push_cmd(2'b11, 4'd5);
      push_cmd(2'b10, 4'd1);
      push_cmd(2'b01, 4'd1);
      push_cmd(2'b11, 4'd0);
      enable = 1'b1;
      @(negedge clk);
      chk("mid_jk", jk, 3);
      chk("mid_level", level, 3);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_jk", jk, 0);
      chk("arst_busy", busy, 0);
      chk("arst_level", level, 0);
      chk("arst_ready", cmd_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      run_trace("post_rst", 6, 16'd0);
      chk("post_rst_busy", busy, 0);

`ifdef JK_SEQ_PRED_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      push_cmd(2'b11, 4'd2);
      wait_idle(20);
      chk("pred_q", q_pred, 1);
      chk("pred_mis0", mismatch, 0);
      q_force = 1'b1;
      @(negedge clk);
      q_force = 1'b0;
      chk("pred_mis1", mismatch, 1);
      repeat (3) @(negedge clk);
      chk("pred_sticky", mismatch, 1);
      reset = 1'b1;
      #1;
      chk("pred_rst_mis", mismatch, 0);
      chk("pred_rst_q", q_pred, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
